// File: rtl/pwm_decoder.sv
// PWM duty decoder: counts high samples of pwm_in over fixed CYCLES_PER_WINDOW-clock windows.
// Optional build macro PWM_DECODER_RESYNC_EN realigns the window on an unexpected rising edge.
module pwm_decoder #(
    parameter  int CYCLES_PER_WINDOW = 1024,
    localparam int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwm_in,
    output logic [CODE_WIDTH-1:0] code,
    output logic                  code_valid,
    output logic                  locked,
    output logic                  resync
);

    typedef enum logic {
        HUNT    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CODE_WIDTH-1:0] LAST_IDX = CODE_WIDTH'(CYCLES_PER_WINDOW - 1);
    localparam logic [CODE_WIDTH-1:0] IDX_ONE  = CODE_WIDTH'(1);
    localparam logic [CODE_WIDTH:0]   ACC_ONE  = (CODE_WIDTH + 1)'(1);

    // [0] metastability stage, [1] pwm_s, [2] pwm_d
    logic [2:0] sync_pipe;
    logic       pwm_s;
    logic       pwm_d;
    logic       rise;

    state_t                state;
    state_t                state_next;
    logic [CODE_WIDTH-1:0] idx;
    logic [CODE_WIDTH-1:0] idx_next;
    logic [CODE_WIDTH:0]   acc;
    logic [CODE_WIDTH:0]   acc_next;
    logic [CODE_WIDTH:0]   sum;
    logic [CODE_WIDTH-1:0] sat_code;
    logic [CODE_WIDTH-1:0] code_next;
    logic                  code_valid_next;
    logic                  window_end;
`ifdef PWM_DECODER_RESYNC_EN
    logic                  resync_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[1:0], pwm_in};
    end

    assign pwm_s = sync_pipe[1];
    assign pwm_d = sync_pipe[2];
    assign rise  = pwm_s & ~pwm_d;

    // acc is one bit wider so an all-high window (count == CYCLES_PER_WINDOW) is visible.
    assign sum        = acc + {{CODE_WIDTH{1'b0}}, pwm_s};
    assign sat_code   = sum[CODE_WIDTH] ? '1 : sum[CODE_WIDTH-1:0];
    assign window_end = (idx == LAST_IDX);

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        acc_next        = acc;
        code_next       = code;
        code_valid_next = 1'b0;
`ifdef PWM_DECODER_RESYNC_EN
        resync_next     = 1'b0;
`endif
        case (state)
            HUNT: begin
                idx_next = '0;
                acc_next = '0;
                if (rise) begin
                    state_next = MEASURE;
                    idx_next   = IDX_ONE;
                    acc_next   = ACC_ONE;
                end
            end
            MEASURE: begin
`ifdef PWM_DECODER_RESYNC_EN
                // An edge off the window boundary means we drifted: drop the window, restart here.
                if (rise && idx != '0) begin
                    idx_next    = IDX_ONE;
                    acc_next    = ACC_ONE;
                    resync_next = 1'b1;
                end else
`endif
                if (window_end) begin
                    code_next       = sat_code;
                    code_valid_next = 1'b1;
                    idx_next        = '0;
                    acc_next        = '0;
                end else begin
                    idx_next = idx + IDX_ONE;
                    acc_next = sum;
                end
            end
            default: begin
                state_next = HUNT;
                idx_next   = '0;
                acc_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            idx        <= '0;
            acc        <= '0;
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            acc        <= acc_next;
            code       <= code_next;
            code_valid <= code_valid_next;
        end
    end

`ifdef PWM_DECODER_RESYNC_EN
    always_ff @(posedge clk) begin
        if (rst) resync <= 1'b0;
        else     resync <= resync_next;
    end
`else
    assign resync = 1'b0;
`endif

    assign locked = (state == MEASURE);

endmodule

// File: tb/tb_pwm_decoder.sv
// Randomized scoreboard bench for pwm_decoder; reference model counts synchronized
// samples per window straight from a per-edge history of pwm_in.
module tb_pwm_decoder;
    localparam int N    = 8;
    localparam int CW   = 3;
    localparam int MAXC = 8192;
`ifdef PWM_DECODER_RESYNC_EN
    localparam bit RESYNC_BUILD = 1'b1;
`else
    localparam bit RESYNC_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_in;
    logic [CW-1:0] code;
    logic          code_valid;
    logic          locked;
    logic          resync;

    pwm_decoder #(.CYCLES_PER_WINDOW(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .code      (code),
        .code_valid(code_valid),
        .locked    (locked),
        .resync    (resync)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned val;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          errors   = 0;
    int          checks   = 0;
    int          cyc      = 0;
    int          last_rst = -100;
    bit          samp[MAXC];
    bit          m_locked = 1'b0;
    int          m_start  = 0;
    bit          m_resync = 1'b0;
    int unsigned held     = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Value of the synchronized sample the DUT acts on at edge t: pwm_in from two edges
    // earlier, forced low if that sample was taken at or before a reset edge.
    function automatic bit s_at(int t);
        if (t - 2 < 0 || t - 2 <= last_rst) return 1'b0;
        return samp[t - 2];
    endfunction

    // Reference model, evaluated at every rising edge.
    always @(posedge clk) begin
        int pos;
        int cnt;
        bit s;
        bit rs;
        exp_t e;
        cyc = cyc + 1;
        if (cyc < MAXC) samp[cyc] = pwm_in;
        m_resync = 1'b0;
        if (rst) begin
            last_rst = cyc;
            m_locked = 1'b0;
        end else begin
            s  = s_at(cyc);
            rs = s && !s_at(cyc - 1);
            if (!m_locked) begin
                if (rs) begin
                    m_locked = 1'b1;
                    m_start  = cyc;
                end
            end else begin
                pos = (cyc - m_start) % N;
                if (RESYNC_BUILD && rs && pos != 0) begin
                    m_start  = cyc;
                    m_resync = 1'b1;
                end else if (pos == N - 1) begin
                    cnt = 0;
                    for (int k = 0; k < N; k++) cnt += int'(s_at(cyc - k));
                    e.val = (cnt > N - 1) ? N - 1 : cnt;
                    e.due = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    // Monitor: compares DUT outputs half a cycle after each edge.
    always @(negedge clk) begin
        bit exp_v;
        if (cyc > 0) begin
            if (last_rst == cyc) held = 0;
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            chk("code_valid", 32'(code_valid), 32'(exp_v));
            if (exp_v) begin
                held = q[0].val;
                void'(q.pop_front());
            end
            chk("code", 32'(code), held);
            chk("locked", 32'(locked), 32'(m_locked));
            chk("resync", 32'(resync), 32'(m_resync));
        end
    end

    task automatic drive(bit v, int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = v;
            @(negedge clk);
        end
    endtask

    task automatic pattern(int h, int reps);
        for (int r = 0; r < reps; r++) begin
            drive(1'b1, h);
            drive(1'b0, N - h);
        end
    endtask

    // Hold inputs until the next edge falls on window index p.
    task automatic wait_pos(int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * N && !hit; i++) begin
            if (m_locked && ((cyc + 1 - m_start) % N) == p) hit = 1'b1;
            else @(negedge clk);
        end
        chk("wait_pos", 32'(hit), 32'd1);
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        drive(1'b0, 40);                  // idle: no lock, no strobes
        pattern(3, 6);                    // steady 3/8 duty
        pattern(3, 1);
        drive(1'b1, 4 * N);               // saturating all-high windows
        pattern(3, 2);
        drive(1'b0, 4 * N);               // all-low windows keep lock

        pattern(3, 3);                    // reset mid-window at idx 4
        wait_pos(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pattern(3, 4);

        pattern(2, 3);                    // misaligned rise at idx 5
        wait_pos(3);
        pattern(2, 4);

        for (int it = 0; it < 40; it++) begin
            int sel;
            int len;
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                pattern($urandom_range(0, N), $urandom_range(1, 3));
            end else if (sel < 9) begin
                len = $urandom_range(1, 20);
                for (int i = 0; i < len; i++) drive(1'($urandom_range(0, 1)), 1);
            end else begin
                rst    = 1'b1;
                pwm_in = 1'($urandom_range(0, 1));
                @(negedge clk);
                rst = 1'b0;
            end
        end

        drive(1'b0, 2 * N);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
